// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and sync-tracker state encoding, used by both the
// generator and the capture side.
package vga_timing_pkg;

  localparam int WIDTH_DEF   = 640;
  localparam int DEPTH_DEF   = 480;
  localparam int H_PULSE_DEF = 96;
  localparam int H_BP_DEF    = 48;
  localparam int H_FP_DEF    = 16;
  localparam int V_PULSE_DEF = 2;
  localparam int V_BP_DEF    = 33;
  localparam int V_FP_DEF    = 10;

  localparam int H_TOTAL = H_PULSE_DEF + H_BP_DEF + WIDTH_DEF + H_FP_DEF;
  localparam int V_TOTAL = V_PULSE_DEF + V_BP_DEF + DEPTH_DEF + V_FP_DEF;

  localparam int H_ACT_START = H_PULSE_DEF + H_BP_DEF;
  localparam int V_ACT_START = V_PULSE_DEF + V_BP_DEF;

  localparam int CNT_W = 10;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } sync_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one active-low sync input and flags its falling edge; history
// resets high so a reset never produces a phantom edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);

  logic d_r;
  logic d_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_r    <= 1'b1;
      d_prev <= 1'b1;
    end else begin
      d_r    <= d;
      d_prev <= d_r;
    end
  end

  assign fall = d_prev & ~d_r;

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers line/frame position from hsync/vsync and emits
// active-area pixels as 8-bit grey with coordinates and frame markers.
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int H_PULSE = H_PULSE_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int V_PULSE = V_PULSE_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int V_FP    = V_FP_DEF
) (
  input  logic                       dclk,
  input  logic                       clr,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic [2:0]                 red,
  input  logic [2:0]                 green,
  input  logic [2:0]                 blue,
  output logic                       pix_valid,
  output logic [7:0]                 pix_data,
  output logic [$clog2(WIDTH)-1:0]   pix_x,
  output logic [$clog2(DEPTH)-1:0]   pix_y,
  output logic                       sof,
  output logic                       eol,
  output logic                       frame_done,
  output logic                       locked,
  output logic                       sync_err
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(H_PULSE + H_BP + WIDTH + H_FP - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(V_PULSE + V_BP + DEPTH + V_FP - 1);
  localparam logic [CNT_W-1:0] H_START    = CNT_W'(H_PULSE + H_BP);
  localparam logic [CNT_W-1:0] H_END      = CNT_W'(H_PULSE + H_BP + WIDTH - 1);
  localparam logic [CNT_W-1:0] V_START    = CNT_W'(V_PULSE + V_BP);
  localparam logic [CNT_W-1:0] V_END      = CNT_W'(V_PULSE + V_BP + DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  function automatic logic [7:0] grey_of(input logic [2:0] r,
                                         input logic [2:0] g,
                                         input logic [2:0] b);
    logic [4:0] s;
    logic [2:0] a;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    a = s[4:2];
    return {a, a, a[2:1]};
  endfunction

  logic hsync_fall;
  logic vsync_fall;

  sync_edge_detect u_hsync_det (
    .clk  (dclk),
    .rst  (clr),
    .d    (hsync),
    .fall (hsync_fall)
  );

  sync_edge_detect u_vsync_det (
    .clk  (dclk),
    .rst  (clr),
    .d    (vsync),
    .fall (vsync_fall)
  );

  // Stage p0: input register, same stage as the sync edge detectors
  logic [2:0] red_r;
  logic [2:0] green_r;
  logic [2:0] blue_r;

  always_ff @(posedge dclk) begin
    red_r   <= red;
    green_r <= green;
    blue_r  <= blue;
  end

  // Stage p1: colour delayed one more cycle to line up with hcount/vcount
  logic [2:0] red_p1;
  logic [2:0] green_p1;
  logic [2:0] blue_p1;

  always_ff @(posedge dclk) begin
    red_p1   <= red_r;
    green_p1 <= green_r;
    blue_p1  <= blue_r;
  end

  sync_state_t      state;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             v_pend;

  logic v_clear;
  logic h_bad;
  logic v_bad;
  logic cnt_lost;
  logic lose_lock;
  logic h_act;
  logic v_act;
  logic pix_now;

  always_comb begin
    v_clear   = hsync_fall && (v_pend || vsync_fall);
    h_bad     = hsync_fall && (hcount != LINE_LAST);
    v_bad     = v_clear && (vcount != FRAME_LAST);
    cnt_lost  = (hcount == CNT_MAX);
    lose_lock = (state == LOCKED) && (h_bad || v_bad || cnt_lost);
    h_act     = (hcount >= H_START) && (hcount <= H_END);
    v_act     = (vcount >= V_START) && (vcount <= V_END);
    // A cycle that drops lock must not also emit a pixel
    pix_now   = (state == LOCKED) && !lose_lock && h_act && v_act;
  end

  // Stage p2: timing tracker, lock FSM and registered pixel outputs
  always_ff @(posedge dclk) begin
    if (clr) begin
      state      <= HUNT;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
      hcount     <= '0;
      vcount     <= '0;
      v_pend     <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      hcount <= hsync_fall ? '0 : hcount + 1'b1;

      if (v_clear) begin
        vcount <= '0;
        v_pend <= 1'b0;
      end else begin
        if (hsync_fall) vcount <= vcount + 1'b1;
        if (vsync_fall) v_pend <= 1'b1;
      end

      case (state)
        HUNT: begin
          if (v_clear) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (lose_lock) begin
            state    <= HUNT;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase

      pix_valid  <= pix_now;
      pix_data   <= pix_now ? grey_of(red_p1, green_p1, blue_p1) : '0;
      pix_x      <= pix_now ? XW'(hcount - H_START) : '0;
      pix_y      <= pix_now ? YW'(vcount - V_START) : '0;
      sof        <= pix_now && (hcount == H_START) && (vcount == V_START);
      eol        <= pix_now && (hcount == H_END);
      frame_done <= pix_now && (hcount == H_END) && (vcount == V_END);
    end
  end

endmodule
